// File: rtl/i2c_byte_master_pkg.sv
// Shared constants for the single-byte I2C master: state encoding and default divider.
package i2c_byte_master_pkg;

    // 50 MHz clk / (4 * 125) = 100 kHz SCL
    localparam int unsigned CLK_DIV_DEFAULT = 125;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_START    = 4'd1,
        ST_ADDR     = 4'd2,
        ST_ADDR_ACK = 4'd3,
        ST_WDATA    = 4'd4,
        ST_WACK     = 4'd5,
        ST_RDATA    = 4'd6,
        ST_MACK     = 4'd7,
        ST_STOP     = 4'd8
    } state_e;

endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-period timer for the I2C master: a down-counter that reloads at
// terminal count, plus a 2-bit phase (Q0..Q3) that advances on every terminal count.
module i2c_phase_gen
    import i2c_byte_master_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    output logic       tick,
    output logic [1:0] phase
);

    localparam logic [9:0] CNT_LOAD = 10'(CLK_DIV - 1);

    logic [9:0] cnt_q, cnt_d;
    logic [1:0] phase_q, phase_d;

    // Next count: reload and step the phase at terminal count, otherwise count down.
    always_comb begin
        cnt_d   = cnt_q - 10'd1;
        phase_d = phase_q;
        if (cnt_q == 10'd0) begin
            cnt_d   = CNT_LOAD;
            phase_d = phase_q + 2'd1;
        end
    end

    // Counter registers; held at the start of Q0 while the master is idle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q   <= CNT_LOAD;
            phase_q <= 2'd0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign tick  = (cnt_q == 10'd0);
    assign phase = phase_q;

endmodule

// File: rtl/i2c_byte_master.sv
// Single-byte I2C master: START, address+rw, one data byte written or read, STOP.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | bus released (scl=1, sda released), waiting for init
// START    | scl high, SDA pulled low halfway through -> start condition
// ADDR     | shift out slave address (7 bits) then rw, MSB first
// ADDR_ACK | release SDA, sample slave ACK; NACK sets ack_err and stops
// WDATA    | shift out the write byte, MSB first
// WACK     | release SDA, sample slave ACK for the data byte
// RDATA    | release SDA, shift in 8 bits from the slave, MSB first
// MACK     | master NACKs the single read byte, then data_out updates
// STOP     | SDA low while scl rises, released in Q3 -> stop condition
module i2c_byte_master
    import i2c_byte_master_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       rw,
    input  logic [6:0] slave_addr,
    input  logic [7:0] data,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_in
);

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] data_out_q, data_out_d;
    logic       rw_q, rw_d;
    logic       ack_err_q, ack_err_d;
    logic       done_q, done_d;

    logic       tick;
    logic [1:0] phase;
    logic       sample;
    logic       slot_end;

    i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == ST_IDLE),
        .tick  (tick),
        .phase (phase)
    );

    // SDA is sampled on the last cycle of Q2; states advance on the last cycle of Q3.
    assign sample   = tick && (phase == 2'd2);
    assign slot_end = tick && (phase == 2'd3);

    // Next-state and datapath updates for the transaction sequencer.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        rw_d       = rw_q;
        ack_err_d  = ack_err_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (init) begin
                    state_d   = ST_START;
                    rw_d      = rw;
                    wdata_d   = data;
                    shift_d   = {slave_addr, rw};
                    bit_cnt_d = 3'd7;
                    ack_err_d = 1'b0;
                end
            end
            ST_START: begin
                if (slot_end) state_d = ST_ADDR;
            end
            ST_ADDR, ST_WDATA: begin
                if (slot_end) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    if (bit_cnt_q == 3'd0) begin
                        state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_WACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end
            end
            ST_ADDR_ACK: begin
                if (sample && sda_in) ack_err_d = 1'b1;
                if (slot_end) begin
                    bit_cnt_d = 3'd7;
                    shift_d   = wdata_q;
                    if (ack_err_q)  state_d = ST_STOP;
                    else if (rw_q)  state_d = ST_RDATA;
                    else            state_d = ST_WDATA;
                end
            end
            ST_WACK: begin
                if (sample && sda_in) ack_err_d = 1'b1;
                if (slot_end) state_d = ST_STOP;
            end
            ST_RDATA: begin
                if (sample) shift_d = {shift_q[6:0], sda_in};
                if (slot_end) begin
                    if (bit_cnt_q == 3'd0) state_d = ST_MACK;
                    else                   bit_cnt_d = bit_cnt_q - 3'd1;
                end
            end
            ST_MACK: begin
                if (slot_end) begin
                    data_out_d = shift_q;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (slot_end) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction without a STOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            wdata_q    <= 8'h00;
            data_out_q <= 8'h00;
            rw_q       <= 1'b0;
            ack_err_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            rw_q       <= rw_d;
            ack_err_q  <= ack_err_d;
            done_q     <= done_d;
        end
    end

    // Pin decode from state and quarter; data bits only move at Q0 via shift_q.
    always_comb begin
        scl    = 1'b1;
        sda_oe = 1'b0;
        unique case (state_q)
            ST_IDLE:           begin scl = 1'b1;     sda_oe = 1'b0;          end
            ST_START:          begin scl = 1'b1;     sda_oe = phase[1];      end
            ST_ADDR, ST_WDATA: begin scl = phase[1]; sda_oe = ~shift_q[7];   end
            ST_STOP:           begin scl = phase[1]; sda_oe = (phase != 2'd3); end
            default:           begin scl = phase[1]; sda_oe = 1'b0;          end
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign ack_err  = ack_err_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master with CLK_DIV=4 (one bit slot = 16 clk).
module tb_i2c_byte_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] slave_addr = 7'h00;
    logic [7:0] data = 8'h00;
    logic [7:0] data_out;
    logic       busy, done, ack_err, scl, sda_oe;
    logic       sda_in;

    int n_chk = 0;
    int n_err = 0;

    // bus monitor state
    int         rises, busy_cycles, done_cnt, hi_toggles;
    logic [7:0] addr_byte, data_byte;
    logic       ack1_oe, ack2_oe;
    logic       scl_prev = 1'b1, oe_prev = 1'b0;

    // slave model: 0 = NACK everything, 1 = ACK, 2 = ACK and return rd_byte
    int         slave_mode = 1;
    logic [7:0] rd_byte = 8'h3C;

    i2c_byte_master #(.CLK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .init       (init),
        .rw         (rw),
        .slave_addr (slave_addr),
        .data       (data),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err),
        .scl        (scl),
        .sda_oe     (sda_oe),
        .sda_in     (sda_in)
    );

    always #5 clk = ~clk;

    always_comb begin
        sda_in = 1'b1;
        if (slave_mode != 0 && (rises == 9 || (slave_mode == 1 && rises == 18)))
            sda_in = 1'b0;
        if (slave_mode == 2 && rises >= 10 && rises <= 17)
            sda_in = rd_byte[17 - rises];
    end

    always @(negedge clk) begin
        if (busy) busy_cycles++;
        if (done) done_cnt++;
        if (scl && !scl_prev) begin
            rises++;
            if (rises <= 8)       addr_byte = {addr_byte[6:0], ~sda_oe};
            else if (rises == 9)  ack1_oe = sda_oe;
            else if (rises <= 17) data_byte = {data_byte[6:0], ~sda_oe};
            else if (rises == 18) ack2_oe = sda_oe;
        end
        if (scl && scl_prev && (sda_oe != oe_prev)) hi_toggles++;
        scl_prev = scl;
        oe_prev  = sda_oe;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        rises = 0; busy_cycles = 0; done_cnt = 0; hi_toggles = 0;
        addr_byte = 8'h00; data_byte = 8'h00; ack1_oe = 1'b1; ack2_oe = 1'b1;
    endtask

    // Presents operands at a negedge; the following posedge is the acceptance edge.
    task automatic start_txn(input logic t_rw, input logic [6:0] t_addr, input logic [7:0] t_data);
        @(negedge clk);
        clear_mon();
        rw = t_rw; slave_addr = t_addr; data = t_data; init = 1'b1;
        @(posedge clk);
        #1 init = 1'b0;
        chk("busy_after_accept", busy, 1'b1);
        chk("ack_err_cleared", ack_err, 1'b0);
    endtask

    // Counts edges from the current point until done is seen, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (cyc < 2000) begin
            @(posedge clk);
            #1 cyc++;
            if (done) break;
        end
        if (!done) chk("done_timeout", done, 1'b1);
        @(negedge clk);
        #1;
    endtask

    int cyc;

    initial begin
        clear_mon();
        // reset with init held high: must be ignored
        init = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", scl, 1'b1);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ack_err", ack_err, 1'b0);
        chk("rst_data_out", data_out, 8'h00);
        @(negedge clk);
        rst = 1'b0; init = 1'b0;
        @(posedge clk);
        #1 chk("idle_after_rst", busy, 1'b0);

        // write 0x50 <- 0xA5, slave ACKs
        slave_mode = 1;
        start_txn(1'b0, 7'h50, 8'hA5);
        wait_done(cyc);
        chk("wr_done_cycle", cyc, 320);
        chk("wr_busy_cycles", busy_cycles, 320);
        chk("wr_addr_byte", addr_byte, 8'hA0);
        chk("wr_addr_ack_rel", ack1_oe, 1'b0);
        chk("wr_data_byte", data_byte, 8'hA5);
        chk("wr_data_ack_rel", ack2_oe, 1'b0);
        chk("wr_ack_err", ack_err, 1'b0);
        chk("wr_done_cnt", done_cnt, 1);
        chk("wr_scl_rises", rises, 19);
        chk("wr_hi_toggles", hi_toggles, 2);
        chk("wr_idle_scl", scl, 1'b1);
        chk("wr_idle_oe", sda_oe, 1'b0);

        // read from 0x50, slave returns 0x3C
        slave_mode = 2;
        start_txn(1'b1, 7'h50, 8'h00);
        wait_done(cyc);
        chk("rd_done_cycle", cyc, 320);
        chk("rd_addr_byte", addr_byte, 8'hA1);
        chk("rd_mack_nack", ack2_oe, 1'b0);
        chk("rd_data_out", data_out, 8'h3C);
        chk("rd_ack_err", ack_err, 1'b0);
        chk("rd_hi_toggles", hi_toggles, 2);

        // address NACK
        slave_mode = 0;
        start_txn(1'b0, 7'h50, 8'hA5);
        wait_done(cyc);
        chk("nack_done_cycle", cyc, 176);
        chk("nack_busy_cycles", busy_cycles, 176);
        chk("nack_ack_err", ack_err, 1'b1);
        chk("nack_scl_rises", rises, 10);
        chk("nack_done_cnt", done_cnt, 1);
        chk("nack_hi_toggles", hi_toggles, 2);
        chk("nack_data_out_held", data_out, 8'h3C);

        // second init during busy with different operands
        slave_mode = 1;
        start_txn(1'b0, 7'h50, 8'hA5);
        repeat (40) @(posedge clk);
        #1;
        rw = 1'b1; slave_addr = 7'h11; data = 8'h22; init = 1'b1;
        @(posedge clk);
        #1 init = 1'b0;
        wait_done(cyc);
        chk("dbl_done_cycle", cyc, 279);
        chk("dbl_addr_byte", addr_byte, 8'hA0);
        chk("dbl_data_byte", data_byte, 8'hA5);
        chk("dbl_done_cnt", done_cnt, 1);
        chk("dbl_hi_toggles", hi_toggles, 2);

        // reset in Q0 of the second WDATA bit slot
        start_txn(1'b0, 7'h50, 8'hA5);
        repeat (177) @(posedge clk);
        #1;
        chk("pre_rst_scl_low", scl, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_scl", scl, 1'b1);
        chk("abort_sda_oe", sda_oe, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, 0);
        chk("abort_stay_idle", busy, 1'b0);

        // clean transaction after the abort
        start_txn(1'b0, 7'h50, 8'hA5);
        wait_done(cyc);
        chk("post_done_cycle", cyc, 320);
        chk("post_addr_byte", addr_byte, 8'hA0);
        chk("post_data_byte", data_byte, 8'hA5);
        chk("post_ack_err", ack_err, 1'b0);
        chk("post_done_cnt", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
